sw_debouncer: RTL and testbench

Synchronous switch/button debouncer for a single mechanical input. It synchronises the raw asynchronous switch into the system clock domain and accepts a new level only after it has been stable for `StableTime` milliseconds. It provides a clean level output and a one-cycle rising-edge tick. It sits directly behind board-level switch/button pins, ahead of any control logic that consumes user input.

---
 rtl/sw_debouncer.sv | 103 ++++++++++
 tb/tb_sw_debouncer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_debouncer.sv
// rtl/sw_debouncer.sv - two-flop synchronised switch debouncer with level output and rising-edge tick
module sw_debouncer #(
  parameter int ClkFreq    = 100_000_000,
  parameter int StableTime = 10
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sw_i,
  output logic db_level_o,
  output logic db_tick_o
);

  localparam int N    = (ClkFreq / 1000) * StableTime;
  localparam int CntW = (N > 2) ? $clog2(N) : 1;

  localparam logic [CntW-1:0] CntMax = CntW'(N - 1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  if (N < 2) begin : g_n_check
    $error("sw_debouncer: stable cycle count must be at least 2");
  end

  // State bits are (level, pending), so the MSB is the debounced level itself.
  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    WAIT1 = 2'b01,
    ONE   = 2'b10,
    WAIT0 = 2'b11
  } state_t;

  state_t          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tick_q, tick_d;
  logic            s1_q, s2_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= ZERO;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      s1_q    <= sw_i;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    case (state_q)
      ZERO: begin
        if (s2_q) begin
          state_d = WAIT1;
          cnt_d   = CntOne;
        end
      end
      WAIT1: begin
        // Any disagreeing sample is treated as bounce and throws away the count.
        if (!s2_q) begin
          state_d = ZERO;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d = ONE;
          cnt_d   = '0;
          tick_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      ONE: begin
        if (!s2_q) begin
          state_d = WAIT0;
          cnt_d   = CntOne;
        end
      end
      WAIT0: begin
        if (s2_q) begin
          state_d = ONE;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d = ZERO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        state_d = ZERO;
        cnt_d   = '0;
      end
    endcase
  end

  assign db_level_o = state_q[1];
  assign db_tick_o  = tick_q;

endmodule

// File: tb/tb_sw_debouncer.sv
// tb/tb_sw_debouncer.sv - scoreboard bench for sw_debouncer with N = 1000 stable cycles
module tb_sw_debouncer;

  localparam int NCYC = 1000;

  localparam logic [1:0] K_RISE = 2'd0;
  localparam logic [1:0] K_FALL = 2'd1;
  localparam logic [1:0] K_TICK = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] cyc;
  } ev_t;

  logic clk;
  logic rst;
  logic sw;
  logic db_level;
  logic db_tick;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  ev_t  exp_q[$];
  ev_t  ev;
  logic prev_level;

  sw_debouncer #(
    .ClkFreq   (1_000_000),
    .StableTime(1)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .sw_i      (sw),
    .db_level_o(db_level),
    .db_tick_o (db_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every observed output event must match the head of the expected queue.
  task automatic monitor();
    logic [1:0] kinds[2];
    bit         has[2];
    prev_level = db_level;
    forever begin
      @(negedge clk);
      has[0]   = (db_level !== prev_level);
      kinds[0] = db_level ? K_RISE : K_FALL;
      has[1]   = (db_tick === 1'b1);
      kinds[1] = K_TICK;
      for (int k = 0; k < 2; k++) begin
        if (has[k]) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL event: got kind %0d at edge %0d, required no event", kinds[k], cyc);
          end else begin
            ev = exp_q.pop_front();
            if (ev.kind !== kinds[k] || ev.cyc !== cyc) begin
              errors++;
              $display("FAIL event: got kind %0d at edge %0d, required kind %0d at edge %0d",
                       kinds[k], cyc, ev.kind, ev.cyc);
            end
          end
        end
      end
      prev_level = db_level;
    end
  endtask

  task automatic wait_edge(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic push_rise(input int e0);
    exp_q.push_back('{kind: K_RISE, cyc: 32'(e0 + NCYC + 1)});
    exp_q.push_back('{kind: K_TICK, cyc: 32'(e0 + NCYC + 1)});
  endtask

  task automatic test_reset();
    int e0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (db_level !== 1'b0 || db_tick !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: level=%b tick=%b, required 0 0", db_level, db_tick);
      end
    end
    @(posedge clk); #1;
    rst = 1'b1;
    e0 = cyc + 1;
    push_rise(e0);
    wait_edge(e0 + NCYC);
    checks++;
    if (db_level !== 1'b0) begin
      errors++;
      $display("FAIL reset_early: level=%b, required 0", db_level);
    end
    wait_edge(e0 + NCYC + 1);
    checks++;
    if (db_level !== 1'b1 || db_tick !== 1'b1) begin
      errors++;
      $display("FAIL reset_rise: level=%b tick=%b, required 1 1", db_level, db_tick);
    end
    wait_edge(e0 + NCYC + 2);
    checks++;
    if (db_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_tick_drop: tick=%b, required 0", db_tick);
    end
  endtask

  task automatic test_clean_release();
    int e0;
    @(posedge clk); #1;
    sw = 1'b0;
    e0 = cyc + 1;
    exp_q.push_back('{kind: K_FALL, cyc: 32'(e0 + NCYC + 1)});
    wait_edge(e0 + NCYC);
    checks++;
    if (db_level !== 1'b1) begin
      errors++;
      $display("FAIL release_early: level=%b, required 1", db_level);
    end
    wait_edge(e0 + NCYC + 1);
    checks++;
    if (db_level !== 1'b0 || db_tick !== 1'b0) begin
      errors++;
      $display("FAIL release_fall: level=%b tick=%b, required 0 0", db_level, db_tick);
    end
    wait_edge(e0 + NCYC + 20);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL release_pending: %0d events outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_clean_press();
    int e0;
    @(posedge clk); #1;
    sw = 1'b1;
    e0 = cyc + 1;
    push_rise(e0);
    wait_edge(e0 + NCYC + 1);
    checks++;
    if (db_level !== 1'b1 || db_tick !== 1'b1) begin
      errors++;
      $display("FAIL press_rise: level=%b tick=%b, required 1 1", db_level, db_tick);
    end
    wait_edge(e0 + NCYC + 2);
    checks++;
    if (db_tick !== 1'b0) begin
      errors++;
      $display("FAIL press_tick_drop: tick=%b, required 0", db_tick);
    end
    wait_edge(e0 + 3000);
    checks++;
    if (exp_q.size() != 0 || db_level !== 1'b1) begin
      errors++;
      $display("FAIL press_hold: pending=%0d level=%b, required 0 1", exp_q.size(), db_level);
    end
  endtask

  task automatic test_bouncy_press();
    int e0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      sw = (i % 2 == 0);
      repeat (49) @(posedge clk);
      @(negedge clk);
      checks++;
      if (db_level !== 1'b0) begin
        errors++;
        $display("FAIL bounce_seg%0d: level=%b, required 0", i, db_level);
      end
    end
    @(posedge clk); #1;
    sw = 1'b1;
    e0 = cyc + 1;
    push_rise(e0);
    wait_edge(e0 + NCYC);
    checks++;
    if (db_level !== 1'b0) begin
      errors++;
      $display("FAIL bounce_early: level=%b, required 0", db_level);
    end
    wait_edge(e0 + NCYC + 1);
    checks++;
    if (db_level !== 1'b1 || db_tick !== 1'b1) begin
      errors++;
      $display("FAIL bounce_rise: level=%b tick=%b, required 1 1", db_level, db_tick);
    end
    wait_edge(e0 + NCYC + 200);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL bounce_pending: %0d events outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_near_miss();
    int e1;
    @(posedge clk); #1;
    sw = 1'b1;
    repeat (NCYC - 1) @(posedge clk);
    #1 sw = 1'b0;
    @(posedge clk); #1;
    sw = 1'b1;
    e1 = cyc + 1;
    push_rise(e1);
    wait_edge(e1 + 5);
    checks++;
    if (db_level !== 1'b0) begin
      errors++;
      $display("FAIL near_miss_glitch: level=%b, required 0", db_level);
    end
    wait_edge(e1 + NCYC);
    checks++;
    if (db_level !== 1'b0) begin
      errors++;
      $display("FAIL near_miss_early: level=%b, required 0", db_level);
    end
    wait_edge(e1 + NCYC + 1);
    checks++;
    if (db_level !== 1'b1 || db_tick !== 1'b1) begin
      errors++;
      $display("FAIL near_miss_rise: level=%b tick=%b, required 1 1", db_level, db_tick);
    end
  endtask

  task automatic test_reset_mid_count();
    int e0;
    int e1;
    @(posedge clk); #1;
    sw = 1'b1;
    e0 = cyc + 1;
    wait_edge(e0 + 501);
    @(posedge clk); #1;
    checks++;
    if (cyc !== e0 + 502) begin
      errors++;
      $display("FAIL midrst_align: edge=%0d, required %0d", cyc, e0 + 502);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    e1 = cyc + 1;
    push_rise(e1);
    wait_edge(e0 + NCYC + 1);
    checks++;
    if (db_level !== 1'b0 || db_tick !== 1'b0) begin
      errors++;
      $display("FAIL midrst_discard: level=%b tick=%b, required 0 0", db_level, db_tick);
    end
    wait_edge(e1 + NCYC);
    checks++;
    if (db_level !== 1'b0) begin
      errors++;
      $display("FAIL midrst_early: level=%b, required 0", db_level);
    end
    wait_edge(e1 + NCYC + 1);
    checks++;
    if (db_level !== 1'b1 || db_tick !== 1'b1) begin
      errors++;
      $display("FAIL midrst_rise: level=%b tick=%b, required 1 1", db_level, db_tick);
    end
  endtask

  initial begin
    rst = 1'b0;
    sw  = 1'b1;
    @(posedge clk); #1;
    fork
      monitor();
    join_none
    test_reset();
    test_clean_release();
    test_clean_press();
    test_clean_release();
    test_bouncy_press();
    test_clean_release();
    test_near_miss();
    test_clean_release();
    test_reset_mid_count();
    repeat (50) @(posedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_pending: %0d events outstanding, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
